// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI flash responder: opcodes, FSM encoding and phase widths.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam int ADDR_PHASE_BITS = 24;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_ID     = 3'd4;
  localparam state_t ST_STAT   = 3'd5;
  localparam state_t ST_IGNORE = 3'd6;

  // Byte idx of a 3-byte JEDEC ID, MSB byte first; 0xFF once the ID is exhausted.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      2'd2:    id_byte = id[7:0];
      default: id_byte = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_edge_sync.sv
// Two-flop synchronizers for the SPI pins plus SCK rise/fall detection.
module spi_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_csn,
  input  logic spi_clk,
  input  logic spi_mosi,
  output logic csn_sync,
  output logic mosi_sync,
  output logic sck_rise,
  output logic sck_fall
);

  logic [1:0] csn_ff;
  logic [1:0] sck_ff;
  logic [1:0] mosi_ff;
  logic       sck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csn_ff  <= 2'b11;
      sck_ff  <= 2'b00;
      mosi_ff <= 2'b00;
      sck_q   <= 1'b0;
    end else begin
      csn_ff  <= {csn_ff[0], spi_csn};
      sck_ff  <= {sck_ff[0], spi_clk};
      mosi_ff <= {mosi_ff[0], spi_mosi};
      sck_q   <= sck_ff[1];
    end
  end

  // Pulses are decoded from flops only, so the FSM acts on the third CLK edge.
  assign csn_sync  = csn_ff[1];
  assign mosi_sync = mosi_ff[1];
  assign sck_rise  = sck_ff[1] & ~sck_q;
  assign sck_fall  = ~sck_ff[1] & sck_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: READ / RDID / RDSR decode with a one-deep byte prefetch.
//   state  | meaning
//   IDLE   | CSN high, bus released
//   CMD    | shifting in the opcode
//   ADDR   | shifting in the 24-bit address
//   DATA   | streaming fetched bytes, prefetching the next one
//   ID     | streaming JEDEC ID, then 0xFF
//   STAT   | streaming status 0x00
//   IGNORE | unknown opcode, MISO stays released until CSN rises
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hC84018
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_csn,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic              underrun
);

  logic csn_s, mosi_s, rise, fall;

  spi_edge_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_csn   (spi_csn),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .csn_sync  (csn_s),
    .mosi_sync (mosi_s),
    .sck_rise  (rise),
    .sck_fall  (fall)
  );

  state_t                     state;
  logic [2:0]                 bit_cnt;
  logic [1:0]                 byte_cnt;
  logic [ADDR_PHASE_BITS-2:0] addr_sh;
  logic [ADDR_PHASE_BITS-1:0] addr_full;
  logic [7:0]                 cmd_byte;
  logic [7:0]                 tx_sh;
  logic [7:0]                 tx_byte;
  logic [7:0]                 staged;
  logic                       staged_valid;
  logic                       fetch_ack;
  logic                       data_hit;
  logic                       boundary;

  assign addr_full = {addr_sh, mosi_s};
  assign cmd_byte  = addr_full[7:0];
  assign fetch_ack = mem_req & mem_valid;
  assign data_hit  = staged_valid | fetch_ack;
  assign boundary  = fall && (bit_cnt == 3'd0) &&
                     (state == ST_DATA || state == ST_ID || state == ST_STAT);

  // A byte arriving in the boundary cycle itself bypasses the staging register.
  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      ST_DATA: tx_byte = staged_valid ? staged : (fetch_ack ? mem_rdata : 8'hFF);
      ST_ID:   tx_byte = id_byte(JEDEC_ID, byte_cnt);
      ST_STAT: tx_byte = 8'h00;
      default: tx_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      byte_cnt     <= 2'd0;
      addr_sh      <= '0;
      tx_sh        <= 8'h00;
      staged       <= 8'h00;
      staged_valid <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      underrun     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fetch_ack) begin
        staged       <= mem_rdata;
        staged_valid <= 1'b1;
        mem_req      <= 1'b0;
      end
      if (csn_s) begin
        state        <= ST_IDLE;
        bit_cnt      <= 3'd0;
        byte_cnt     <= 2'd0;
        staged_valid <= 1'b0;
        spi_miso     <= 1'b0;
        spi_miso_oe  <= 1'b0;
        mem_req      <= 1'b0;
      end else begin
        if (rise && state != ST_IDLE) begin
          bit_cnt <= bit_cnt + 3'd1;
          addr_sh <= addr_full[ADDR_PHASE_BITS-2:0];
        end
        case (state)
          ST_IDLE: state <= ST_CMD;
          ST_CMD: begin
            if (rise && bit_cnt == 3'd7) begin
              byte_cnt <= 2'd0;
              case (cmd_byte)
                OP_READ: state <= ST_ADDR;
                OP_RDID: state <= ST_ID;
                OP_RDSR: state <= ST_STAT;
                default: state <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (rise && bit_cnt == 3'd7) begin
              if (byte_cnt == 2'd2) begin
                state    <= ST_DATA;
                byte_cnt <= 2'd0;
                mem_addr <= addr_full[ADDR_W-1:0];
                mem_req  <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
          end
          default: ;
        endcase
        if (boundary) begin
          spi_miso_oe <= 1'b1;
          spi_miso    <= tx_byte[7];
          tx_sh       <= {tx_byte[6:0], 1'b0};
          if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
          if (state == ST_DATA) begin
            if (data_hit) begin
              staged_valid <= 1'b0;
              mem_addr     <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              mem_req      <= 1'b1;
            end else begin
              underrun <= 1'b1;
            end
          end
        end else if (fall && spi_miso_oe) begin
          spi_miso <= tx_sh[7];
          tx_sh    <= {tx_sh[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench: SPI master tasks, latency-configurable memory model, byte/address queues.
module tb_spi_flash_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_valid = 1'b0;
  logic        underrun;

  spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(24'hC84018)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_csn     (spi_csn),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q[$];
  logic [23:0] exp_addr_q[$];
  logic [23:0] mem_log[$];

  bit mem_auto = 1'b1;
  int lat = 0;
  int wait_cnt = 0;
  int ur_cnt = 0;
  bit req_seen = 1'b0;
  bit oe_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: returns addr[7:0] after lat idle cycles, logs each served address.
  always @(negedge clk) begin
    if (underrun) ur_cnt++;
    if (mem_req) req_seen = 1'b1;
    if (spi_miso_oe) oe_seen = 1'b1;
    if (mem_auto) begin
      if (mem_valid) begin
        mem_valid = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt >= lat) begin
          mem_valid = 1'b1;
          mem_rdata = mem_addr[7:0];
          mem_log.push_back(mem_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic csn_begin();
    spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic csn_end();
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  // Opcode, optional address, then n data bytes each compared against the scoreboard.
  task automatic spi_cmd(input logic [7:0] op, input logic [23:0] addr, input bit with_addr,
                         input int n, input string tag);
    logic [7:0] rx;
    logic [7:0] e;
    spi_bits(op, 8, rx);
    if (with_addr) begin
      spi_bits(addr[23:16], 8, rx);
      spi_bits(addr[15:8], 8, rx);
      spi_bits(addr[7:0], 8, rx);
    end
    for (int b = 0; b < n; b++) begin
      spi_bits(8'h00, 8, rx);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, b), {24'h0, rx}, {24'h0, e});
    end
  endtask

  task automatic check_addrs(input string tag);
    logic [23:0] a;
    int k = 0;
    while (exp_addr_q.size() > 0) begin
      a = (mem_log.size() > 0) ? mem_log.pop_front() : 24'hxxxxxx;
      chk($sformatf("%s_addr%0d", tag, k), {8'h0, a}, {8'h0, exp_addr_q.pop_front()});
      k++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, {31'h0, spi_miso}, 32'h0);
    chk({tag, "_oe"}, {31'h0, spi_miso_oe}, 32'h0);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_addr"}, {8'h0, mem_addr}, 32'h0);
    chk({tag, "_underrun"}, {31'h0, underrun}, 32'h0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // RDID
    req_seen = 1'b0;
    exp_q.push_back(8'hC8); exp_q.push_back(8'h40);
    exp_q.push_back(8'h18); exp_q.push_back(8'hFF);
    csn_begin();
    spi_cmd(8'h9F, 24'h0, 1'b0, 4, "rdid");
    csn_end();
    chk("rdid_no_req", {31'h0, req_seen}, 32'h0);

    // READ at 0x10, zero latency
    lat = 0; ur_cnt = 0; mem_log.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) exp_addr_q.push_back(24'h10 + 24'(i));
    csn_begin();
    spi_cmd(8'h03, 24'h000010, 1'b1, 4, "read10");
    csn_end();
    check_addrs("read10");
    chk("read10_no_underrun", ur_cnt, 0);

    // READ wrapping past the top of the address space
    mem_log.delete();
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_addr_q.push_back(24'hFFFFFE); exp_addr_q.push_back(24'hFFFFFF);
    exp_addr_q.push_back(24'h000000); exp_addr_q.push_back(24'h000001);
    csn_begin();
    spi_cmd(8'h03, 24'hFFFFFE, 1'b1, 4, "wrap");
    csn_end();
    check_addrs("wrap");

    // Slow first fetch -> one underrun byte, then the requested data
    lat = 20; ur_cnt = 0;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h40); exp_q.push_back(8'h41);
    csn_begin();
    spi_cmd(8'h03, 24'h000040, 1'b1, 3, "slow");
    csn_end();
    chk("slow_underrun_pulses", ur_cnt, 1);

    // CSN raised mid-byte with a fetch pending
    lat = 1000;
    csn_begin();
    spi_cmd(8'h03, 24'h000080, 1'b1, 0, "abort");
    spi_bits(8'h00, 3, rx);
    chk("abort_req_pending", {31'h0, mem_req}, 32'h1);
    spi_csn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_req_dropped", {31'h0, mem_req}, 32'h0);
    chk("abort_oe_dropped", {31'h0, spi_miso_oe}, 32'h0);
    mem_auto = 1'b0;
    mem_rdata = 8'h5A; mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("late_valid_no_req", {31'h0, mem_req}, 32'h0);
    mem_auto = 1'b1; lat = 0;
    repeat (4 * HALF) @(negedge clk);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    csn_begin();
    spi_cmd(8'h05, 24'h0, 1'b0, 2, "rdsr");
    csn_end();
    exp_q.push_back(8'h20);
    csn_begin();
    spi_cmd(8'h03, 24'h000020, 1'b1, 1, "post_abort");
    csn_end();

    // Unknown opcode keeps MISO released
    oe_seen = 1'b0;
    csn_begin();
    spi_cmd(8'hAB, 24'h0, 1'b0, 0, "ignore");
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    csn_end();
    chk("ignore_oe_low", {31'h0, oe_seen}, 32'h0);

    // Asynchronous reset in the middle of a READ
    csn_begin();
    spi_cmd(8'h03, 24'h000030, 1'b1, 0, "rst_mid");
    spi_bits(8'h00, 3, rx);
    chk("rst_mid_oe_before", {31'h0, spi_miso_oe}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    csn_begin();
    spi_cmd(8'h03, 24'h000030, 1'b1, 2, "after_rst");
    csn_end();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Fabric-side SPI flash responder: the device end of the SoC's quad-pin flash SPI interface (CSN/CLK/MOSI/MISO). It samples the SPI bus, decodes a read-only flash command subset (READ 0x03, RDID 0x9F, RDSR 0x05), and fetches data bytes through a simple request/valid byte port. It is used as a BRAM-backed boot-image emulator in place of an external flash, and as a bus-functional responder in SoC simulation.

## Interface
- ADDR_W, 24: flash byte-address width; the address phase is always 24 bits, and only the low ADDR_W bits are used.
- JEDEC_ID, 24'hC84018: 3-byte ID returned by RDID, MSB byte first.
- CLK  in  1  system clock; must be ≥ 8× SPI_CLK frequency.
- RSTN  in  1  reset, asynchronous assert, active-low.
- SPI_CSN  in  1  chip select, active-low, asynchronous to CLK.
- SPI_CLK  in  1  SPI mode 0 clock, asynchronous to CLK.
- SPI_MOSI  in  1  command/address data from the master.
- SPI_MISO  out  1  data to the master.
- SPI_MISO_OE  out  1  tristate enable for SPI_MISO; high only in data phases.
- MEM_REQ  out  1  byte fetch request; held high until MEM_VALID.
- MEM_ADDR  out  ADDR_W  byte address; stable while MEM_REQ is high.
- MEM_RDATA  in  8  fetched byte; qualified by MEM_VALID.
- MEM_VALID  in  1  single-cycle completion of the outstanding request.
- UNDERRUN  out  1  one-CLK pulse when a data byte was due but not yet fetched.

## Operation
- Synchronize SPI_CSN, SPI_CLK and SPI_MOSI through 2 flops each. Detect SCK rise and fall from the synchronized SPI_CLK.
- Sample MOSI on the rise. Update MISO on the fall. Bit order is MSB first. The bit counter is 3 bits, and the byte counter saturates.
- States:
  - IDLE: CSN high. Enter CMD when the synchronized CSN falls.
  - CMD: collect 8 bits, then dispatch.
    - 0x03 → ADDR.
    - 0x9F → ID.
    - 0x05 → STAT.
    - Any other opcode → IGNORE.
  - ADDR: collect 24 bits. On the 24th rise, set MEM_ADDR to addr[ADDR_W-1:0], raise MEM_REQ, and go to DATA.
  - DATA: at each byte boundary (the fall after bit 0 of the previous byte, or after the last address bit), load the staged byte into the shift register. Then increment the address (modulo 2^ADDR_W) and issue the next MEM_REQ immediately (prefetch depth 1).
  - ID: shift the JEDEC_ID bytes, then 0xFF for any further bytes.
  - STAT: shift 0x00 repeatedly (never busy, never write-enabled).
  - IGNORE: MISO_OE stays low until CSN goes high.
- MEM_VALID captures MEM_RDATA into a staging register and sets staged_valid. Loading the staged byte into the shift register clears staged_valid.
- Underrun: if staged_valid is 0 at a byte boundary, shift 0xFF and pulse UNDERRUN. The outstanding request stays pending, and its data serves the next byte.
- CSN high in any state:
  - return to IDLE within the sync latency;
  - MISO_OE goes to 0;
  - MEM_REQ drops, the pending request is abandoned, and a later MEM_VALID is ignored;
  - staged_valid clears.
- Simultaneous MEM_VALID and byte boundary in the same cycle: the new data is loaded directly (no underrun).

## Timing
- Reset values:
  - SPI_MISO 0, SPI_MISO_OE 0.
  - MEM_REQ 0, MEM_ADDR 0, UNDERRUN 0.
  - State IDLE, staged_valid 0.
- Input-to-action latency is 3 CLK (2 sync + 1 edge register). The MISO update lands ≤ 3 CLK after the SCK fall, which fits within half an SCK period at the 8× ratio.
- MEM_REQ rises 1 CLK after the 24th address rise is detected.
- MEM_VALID is accepted in any cycle with MEM_REQ high, including the first. MEM_REQ falls in the cycle after MEM_VALID.
- The first data byte requires MEM_VALID within 1 CLK of MEM_REQ at the minimum 8× ratio. Subsequent bytes have about 8 SCK periods of slack.
- MISO_OE rises on the fall that drives the first data bit and falls ≤ 3 CLK after the CSN rise.
- Reset asserted mid-transfer forces all outputs to reset values immediately (asynchronous).

## Structure
- Package spi_flash_pkg holds:
  - opcode constants OP_READ, OP_RDID, OP_RDSR;
  - the state enum (IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE);
  - ADDR_PHASE_BITS = 24.
- One sub-module, spi_edge_sync: the 2-flop synchronizers plus the registered rise/fall pulses and the synchronized CSN/MOSI.
- The top contains the FSM, shift registers, address counter and fetch handshake.

## Test plan
- RDID: CSN low, shift 0x9F, then 32 clocks → MISO bytes C8 40 18 FF; MEM_REQ never asserted.
- READ at 0x000010 with a 0-latency memory returning addr[7:0] → bytes 10 11 12 13; MEM_ADDR sequence 0x10..0x14; UNDERRUN never pulses.
- READ at 0xFFFFFE, 4 bytes → MEM_ADDR FFFFFE, FFFFFF, 000000, 000001 (wrap).
- Memory with a first-byte latency of 20 CLK → first byte 0xFF with one UNDERRUN pulse; the second byte is the data for the requested address.
- CSN raised mid-byte during READ with MEM_REQ pending → MEM_REQ low and MISO_OE low within 3 CLK; a late MEM_VALID is ignored; a following RDSR returns 0x00.
- Opcode 0xAB → MISO_OE stays 0 for the whole transaction; RSTN pulsed mid-READ → all outputs at reset values, and the next READ works.
